spi_slave: RTL and testbench
============================

Name: spi_slave

Overview:
- SPI slave (responder) for the 16-bit SPI master link; sits on the far side of the SCLK/MOSI/MISO/LOAD wires.
- Oversamples the master's SCLK, MOSI and LOAD in the local clk domain.
- Shifts one full-duplex word per frame: a receive word into DO and a transmit word from a DI holding register out on MISO.
- Link format: SPI mode 0, MSB first, LOAD low for the whole frame.

Parameters:
- M, 16, word width in bits.
- SYNC_STAGES, 2, synchronizer depth for SCLK/MOSI/LOAD (minimum 2).

Ports:
- clk  input  1  system clock, 50 MHz; must be at least 8x SCLK.
- clr_n  input  1  asynchronous active-low reset.
- SCLK  input  1  serial clock from master; idle 0.
- MOSI  input  1  serial data from master, valid on SCLK rising.
- LOAD  input  1  frame select from master; active-low, idle 1.
- MISO  output  1  serial data to master; changes after SCLK falling.
- DI  input  M  transmit word.
- di_we  input  1  one-cycle strobe; writes DI into tx_hold.
- tx_pending  output  1  tx_hold written since the last frame start.
- DO  output  M  last received word.
- do_valid  output  1  one-cycle pulse when DO updates.
- bit_cnt  output  8  SCLK rising edges counted in the current or last frame.
- frame_err  output  1  one-cycle pulse on a frame whose length is not M.
- busy  output  1  state is SHIFT.

Behaviour:
- Reset: all outputs 0 and tx_hold=0. State goes to IDLE. SCLK synchronizer resets to 0. LOAD synchronizer resets to 0 (asserted), so no frame starts until LOAD has been seen high.
- Edge detect: compare the last synchronizer stage with a delayed copy to form sclk_rise, sclk_fall, load_fall and load_rise, each one clk wide.
- IDLE:
  - On load_fall: tx_sr<=tx_hold, tx_pending<=0, bit_cnt<=0, go to SHIFT.
  - With no new di_we, the old tx_hold is resent.
- SHIFT:
  - On sclk_rise: rx_sr<={rx_sr[M-2:0],MOSI_sync}; bit_cnt increments and saturates at 255.
  - On sclk_fall: tx_sr<=tx_sr<<1.
  - On load_rise: go to DONE.
  - If sclk_rise and load_rise occur in the same cycle, the bit is taken first, then the frame ends.
- DONE, one cycle:
  - If bit_cnt==M: DO<=rx_sr and do_valid=1.
  - Otherwise: frame_err=1 and DO is handled per the optional feature.
  - Then go to IDLE. If load_fall occurs in the DONE cycle, apply the IDLE start actions and go directly to SHIFT.
- MISO:
  - In SHIFT it equals tx_sr[M-1].
  - Otherwise it is 0 (no tristate).
  - The first bit is valid SYNC_STAGES+1 clk after LOAD falls, well before the master's first SCLK rise (25 clk).
- Latency: do_valid asserts exactly SYNC_STAGES+2 clk edges after the first clk edge that samples LOAD high.
- di_we:
  - Writes tx_hold and sets tx_pending at any time.
  - If di_we coincides with a frame start, the frame uses the old tx_hold; the new value is stored and tx_pending stays 1.
  - The master sees the first bit of a write made while busy only in the next frame.
- Reset mid-frame: everything is cleared immediately. A frame in progress is discarded; the slave waits for LOAD high, then a new fall.
- SCLK edges outside SHIFT are ignored.

Optional Feature:
SPI_SLAVE_FRAME_CHK_EN
- Defined: a frame with bit_cnt!=M pulses frame_err, and DO and do_valid stay unchanged.
- Not defined: frame_err is tied 0. Every frame end loads DO<=rx_sr and pulses do_valid, regardless of bit_cnt; a short frame yields the last bit_cnt bits, right-aligned with the old rx_sr content above them.

Test Plan:
- Reset check: pulse clr_n low, then release -> DO=0, MISO=0, do_valid=0, busy=0, tx_pending=0, bit_cnt=0.
- Word exchange:
  - Stimulus: di_we with DI=16'hA5C3, then the master sends 16'h3C5A at 1 MHz SCLK.
  - Response: the master's received word is 16'hA5C3; slave DO=16'h3C5A with a single do_valid pulse; bit_cnt=16; tx_pending=0.
- Back-to-back frames, no new di_we, master sends 16'hFFFF -> MISO again carries 16'hA5C3; DO=16'hFFFF.
- Short frame: master raises LOAD after 8 SCLK rising edges, with FRAME_CHK_EN defined -> frame_err pulse, bit_cnt=8, DO keeps its previous value, no do_valid.
- Reset mid-frame:
  - Stimulus: clr_n low after 5 bits, with LOAD held low across the release.
  - Response: busy=0, no do_valid. The next LOAD high->low then a full 16-bit frame is received correctly.
- Write collision:
  - Stimulus: di_we with DI=16'h1234 in the same clk as the frame-start edge, while tx_hold=16'hA5C3.
  - Response: the current frame sends 16'hA5C3, tx_pending=1, and the next frame sends 16'h1234.

Source files
------------

// File: rtl/spi_slave.sv
// spi_slave: mode-0 MSB-first SPI responder oversampled in clk, with a DI holding register.
// Define SPI_SLAVE_FRAME_CHK_EN to drop frames whose length is not M and pulse frame_err instead.
module spi_slave #(
    parameter int M           = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         SCLK,
    input  logic         MOSI,
    input  logic         LOAD,
    output logic         MISO,
    input  logic [M-1:0] DI,
    input  logic         di_we,
    output logic         tx_pending,
    output logic [M-1:0] DO,
    output logic         do_valid,
    output logic [7:0]   bit_cnt,
    output logic         frame_err,
    output logic         busy
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t                 state_q;
    logic [SYNC_STAGES-1:0] sclk_q, mosi_q, load_q;
    logic                   sclk_dly_q, mosi_dly_q, load_dly_q;
    logic                   sclk_rise_q, sclk_fall_q, load_rise_q, load_fall_q;
    logic [M-1:0]           tx_hold_q, tx_sr_q, rx_sr_q, do_q;
    logic [7:0]             cnt_q;
    logic                   pend_q, valid_q, err_q;
    logic                   sclk_s, mosi_s, load_s;

    assign sclk_s = sclk_q[SYNC_STAGES-1];
    assign mosi_s = mosi_q[SYNC_STAGES-1];
    assign load_s = load_q[SYNC_STAGES-1];

    // Edge pulses are registered, so the data bit is taken from the equally delayed MOSI copy.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            sclk_q      <= '0;
            mosi_q      <= '0;
            load_q      <= '0;
            sclk_dly_q  <= 1'b0;
            mosi_dly_q  <= 1'b0;
            load_dly_q  <= 1'b0;
            sclk_rise_q <= 1'b0;
            sclk_fall_q <= 1'b0;
            load_rise_q <= 1'b0;
            load_fall_q <= 1'b0;
        end else begin
            sclk_q      <= {sclk_q[SYNC_STAGES-2:0], SCLK};
            mosi_q      <= {mosi_q[SYNC_STAGES-2:0], MOSI};
            load_q      <= {load_q[SYNC_STAGES-2:0], LOAD};
            sclk_dly_q  <= sclk_s;
            mosi_dly_q  <= mosi_s;
            load_dly_q  <= load_s;
            sclk_rise_q <= sclk_s & ~sclk_dly_q;
            sclk_fall_q <= ~sclk_s & sclk_dly_q;
            load_rise_q <= load_s & ~load_dly_q;
            load_fall_q <= ~load_s & load_dly_q;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q   <= IDLE;
            tx_hold_q <= '0;
            tx_sr_q   <= '0;
            rx_sr_q   <= '0;
            do_q      <= '0;
            cnt_q     <= '0;
            pend_q    <= 1'b0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            if (di_we) begin
                tx_hold_q <= DI;
                pend_q    <= 1'b1;
            end
            case (state_q)
                SHIFT: begin
                    if (sclk_rise_q) begin
                        rx_sr_q <= {rx_sr_q[M-2:0], mosi_dly_q};
                        cnt_q   <= cnt_q + {7'd0, cnt_q != 8'hFF};
                    end
                    if (sclk_fall_q) tx_sr_q <= tx_sr_q << 1;
                    if (load_rise_q) state_q <= DONE;
                end
                DONE: begin
`ifdef SPI_SLAVE_FRAME_CHK_EN
                    if (cnt_q == 8'(M)) begin
                        do_q    <= rx_sr_q;
                        valid_q <= 1'b1;
                    end else begin
                        err_q   <= 1'b1;
                    end
`else
                    do_q    <= rx_sr_q;
                    valid_q <= 1'b1;
`endif
                    state_q <= IDLE;
                end
                default: ;
            endcase
            // A fall seen in DONE starts the next frame without passing through IDLE.
            if (load_fall_q && state_q != SHIFT) begin
                tx_sr_q <= tx_hold_q;
                pend_q  <= di_we;
                cnt_q   <= '0;
                state_q <= SHIFT;
            end
        end
    end

    assign busy       = state_q == SHIFT;
    assign MISO       = busy & tx_sr_q[M-1];
    assign tx_pending = pend_q;
    assign DO         = do_q;
    assign do_valid   = valid_q;
    assign bit_cnt    = cnt_q;
    assign frame_err  = err_q;
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed frame table plus mid-frame reset and write-collision sequences.
module tb_spi_slave;
    logic        clk, clr_n, SCLK, MOSI, LOAD, di_we;
    logic [15:0] DI;
    logic        MISO, tx_pending, do_valid, frame_err, busy;
    logic [15:0] DO;
    logic [7:0]  bit_cnt;
    int          total, bad, nvalid, nerr, nv0, ne0, lat;
    logic [15:0] rx;

    typedef struct {
        logic        we;
        logic [15:0] di;
        logic        col;
        logic [15:0] cdi;
        logic [15:0] mosi;
        int          nbits;
        logic [15:0] exp_rx;
        logic [15:0] exp_do;
        int          exp_valid;
        int          exp_err;
        int          exp_cnt;
        logic        exp_pend;
    } vec_t;
    vec_t vec[7];

    spi_slave #(.M(16), .SYNC_STAGES(2)) dut (
        .clk(clk), .clr_n(clr_n), .SCLK(SCLK), .MOSI(MOSI), .LOAD(LOAD), .MISO(MISO),
        .DI(DI), .di_we(di_we), .tx_pending(tx_pending), .DO(DO), .do_valid(do_valid),
        .bit_cnt(bit_cnt), .frame_err(frame_err), .busy(busy)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (do_valid) nvalid++;
        if (frame_err) nerr++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic xfer(input logic [15:0] w, input int n, input logic col, input logic [15:0] cdi,
                        output logic [15:0] r, output int l);
        logic [15:0] s;
        s = w;
        r = '0;
        l = 0;
        LOAD = 1'b0;
        MOSI = s[15];
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (col && k == 3) DI = cdi;
            di_we = col && k == 3;
        end
        chk("busy_in_frame", busy, 1);
        for (int i = 0; i < n; i++) begin
            r = {r[14:0], MISO};
            SCLK = 1'b1;
            repeat (25) @(negedge clk);
            SCLK = 1'b0;
            s = s << 1;
            MOSI = s[15];
            repeat (25) @(negedge clk);
        end
        LOAD = 1'b1;
        MOSI = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (do_valid && l == 0) l = k;
        end
    endtask

    initial begin
        vec[0] = '{1'b1, 16'hA5C3, 1'b0, 16'h0000, 16'h3C5A, 16, 16'hA5C3, 16'h3C5A, 1, 0, 16, 1'b0};
        vec[1] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 16'hFFFF, 16, 16'hA5C3, 16'hFFFF, 1, 0, 16, 1'b0};
        vec[2] = '{1'b1, 16'h8001, 1'b0, 16'h0000, 16'h0001, 16, 16'h8001, 16'h0001, 1, 0, 16, 1'b0};
`ifdef SPI_SLAVE_FRAME_CHK_EN
        vec[3] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 16'hAB00, 8, 16'h0080, 16'h0001, 0, 1, 8, 1'b0};
`else
        vec[3] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 16'hAB00, 8, 16'h0080, 16'h01AB, 1, 0, 8, 1'b0};
`endif
        vec[4] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 16'hC3A5, 16, 16'h8001, 16'hC3A5, 1, 0, 16, 1'b0};
        vec[5] = '{1'b1, 16'hA5C3, 1'b1, 16'h1234, 16'h0F0F, 16, 16'hA5C3, 16'h0F0F, 1, 0, 16, 1'b1};
        vec[6] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 16'hF0F0, 16, 16'h1234, 16'hF0F0, 1, 0, 16, 1'b0};
        clr_n = 1'b0;
        SCLK  = 1'b0;
        MOSI  = 1'b0;
        LOAD  = 1'b1;
        DI    = '0;
        di_we = 1'b0;
        repeat (3) @(negedge clk);
        clr_n = 1'b1;
        @(negedge clk);
        chk("rst_do", DO, 0);
        chk("rst_miso", MISO, 0);
        chk("rst_valid", do_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pend", tx_pending, 0);
        chk("rst_cnt", bit_cnt, 0);
        chk("rst_err", frame_err, 0);
        repeat (10) @(negedge clk);
        nv0 = nvalid;
        LOAD = 1'b0;
        repeat (25) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            SCLK = 1'b1;
            repeat (25) @(negedge clk);
            SCLK = 1'b0;
            repeat (25) @(negedge clk);
        end
        chk("mid_busy_pre", busy, 1);
        chk("mid_cnt_pre", bit_cnt, 5);
        clr_n = 1'b0;
        #1;
        chk("mid_busy_rst", busy, 0);
        chk("mid_cnt_rst", bit_cnt, 0);
        repeat (3) @(negedge clk);
        clr_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("mid_busy_held_low", busy, 0);
        chk("mid_no_valid", nvalid - nv0, 0);
        chk("mid_do", DO, 0);
        LOAD = 1'b1;
        repeat (10) @(negedge clk);
        nv0 = nvalid;
        xfer(16'h5AA5, 16, 1'b0, 16'h0000, rx, lat);
        chk("mid_next_rx", rx, 16'h0000);
        chk("mid_next_do", DO, 16'h5AA5);
        chk("mid_next_valid", nvalid - nv0, 1);
        chk("mid_next_lat", lat, 5);
        repeat (5) @(negedge clk);
        for (int v = 0; v < 7; v++) begin
            if (vec[v].we) begin
                DI = vec[v].di;
                di_we = 1'b1;
                @(negedge clk);
                di_we = 1'b0;
                chk($sformatf("v%0d_pend_set", v), tx_pending, 1);
            end
            nv0 = nvalid;
            ne0 = nerr;
            xfer(vec[v].mosi, vec[v].nbits, vec[v].col, vec[v].cdi, rx, lat);
            chk($sformatf("v%0d_master_rx", v), rx, vec[v].exp_rx);
            chk($sformatf("v%0d_do", v), DO, vec[v].exp_do);
            chk($sformatf("v%0d_valid_pulses", v), nvalid - nv0, vec[v].exp_valid);
            chk($sformatf("v%0d_err_pulses", v), nerr - ne0, vec[v].exp_err);
            chk($sformatf("v%0d_bit_cnt", v), bit_cnt, vec[v].exp_cnt);
            chk($sformatf("v%0d_pend", v), tx_pending, vec[v].exp_pend);
            chk($sformatf("v%0d_busy_end", v), busy, 0);
            chk($sformatf("v%0d_miso_idle", v), MISO, 0);
            if (vec[v].exp_valid != 0) chk($sformatf("v%0d_latency", v), lat, 5);
            repeat (5) @(negedge clk);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
